// File: rtl/exception_handler.sv
// Exception/ERET sequencer for the AM stage: picks the highest-priority trigger,
// pulses the CP0 commit for one cycle, flushes the pipe and holds a redirect until fetch accepts it.
module exception_handler #(
  parameter int          N_HWINT     = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_HWINT-1:0] hw_int,
  input  logic [1:0]         sw_int,
  input  logic [N_HWINT+1:0] int_mask,
  input  logic               status_ie,
  input  logic               status_exl,
  input  logic               am_valid,
  input  logic [4:0]         am_excep_code,
  input  logic [31:0]        am_pc,
  input  logic [31:0]        am_data_addr,
  input  logic [31:0]        cp0_epc,
  input  logic               am_is_bd,
  input  logic               am_adel_if,
  input  logic               am_eret,
  input  logic               redirect_ready,
  output logic               excep_valid,
  output logic               eret_commit,
  output logic [4:0]         excep_code,
  output logic [31:0]        epc,
  output logic [31:0]        badvaddr,
  output logic [31:0]        redirect_pc,
  output logic               is_bd,
  output logic               we_badvaddr,
  output logic               flush,
  output logic               redirect_valid,
  output logic               busy
);

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  function automatic logic code_supported(input logic [4:0] code);
    case (code)
      5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12: code_supported = 1'b1;
      default:                              code_supported = 1'b0;
    endcase
  endfunction

  state_t             state;
  logic [N_HWINT-1:0] sync_q [SYNC_STAGES];
  logic [N_HWINT-1:0] hw_sync;
  logic [N_HWINT+1:0] pending;
  logic               int_take;

  logic               trig;
  logic               trig_eret;
  logic [4:0]         trig_code;
  logic [31:0]        trig_badvaddr;
  logic               trig_we_badvaddr;
  logic [31:0]        trig_epc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign hw_sync  = sync_q[SYNC_STAGES-1];
  assign pending  = {hw_sync, sw_int} & int_mask;
  assign int_take = (|pending) & status_ie & ~status_exl & am_valid;
  assign trig_epc = am_is_bd ? (am_pc - 32'd4) : am_pc;

  // Trigger selection: interrupt, then the synchronous codes, then ERET.
  always_comb begin
    trig             = 1'b0;
    trig_eret        = 1'b0;
    trig_code        = CODE_INT;
    trig_badvaddr    = '0;
    trig_we_badvaddr = 1'b0;
    if (int_take) begin
      trig = 1'b1;
    end else if (am_valid && code_supported(am_excep_code)) begin
      trig      = 1'b1;
      trig_code = am_excep_code;
      if (am_excep_code == CODE_ADEL) begin
        trig_we_badvaddr = 1'b1;
        trig_badvaddr    = am_adel_if ? am_pc : am_data_addr;
      end else if (am_excep_code == CODE_ADES) begin
        trig_we_badvaddr = 1'b1;
        trig_badvaddr    = am_data_addr;
      end
    end else if (am_valid && am_eret) begin
      trig      = 1'b1;
      trig_eret = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      excep_valid    <= 1'b0;
      eret_commit    <= 1'b0;
      excep_code     <= '0;
      epc            <= '0;
      badvaddr       <= '0;
      redirect_pc    <= '0;
      is_bd          <= 1'b0;
      we_badvaddr    <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state       <= FLUSH;
            excep_valid <= ~trig_eret;
            eret_commit <= trig_eret;
            excep_code  <= trig_code;
            epc         <= trig_epc;
            is_bd       <= am_is_bd;
            badvaddr    <= trig_badvaddr;
            we_badvaddr <= trig_we_badvaddr;
            redirect_pc <= trig_eret ? cp0_epc : EXC_VECTOR;
            flush       <= 1'b1;
            busy        <= 1'b1;
          end
        end
        FLUSH: begin
          state          <= REDIRECT;
          excep_valid    <= 1'b0;
          eret_commit    <= 1'b0;
          redirect_valid <= 1'b1;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= IDLE;
            excep_code     <= '0;
            epc            <= '0;
            badvaddr       <= '0;
            redirect_pc    <= '0;
            is_bd          <= 1'b0;
            we_badvaddr    <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_handler.sv
// Directed bench for exception_handler: trigger priority, captured fields,
// FLUSH/REDIRECT handshake, interrupt synchroniser latency and asynchronous reset.
module tb_exception_handler;

  logic        clk;
  logic        resetn;
  logic [5:0]  hw_int;
  logic [1:0]  sw_int;
  logic [7:0]  int_mask;
  logic        status_ie, status_exl;
  logic        am_valid;
  logic [4:0]  am_excep_code;
  logic [31:0] am_pc, am_data_addr, cp0_epc;
  logic        am_is_bd, am_adel_if, am_eret;
  logic        redirect_ready;
  logic        excep_valid, eret_commit;
  logic [4:0]  excep_code;
  logic [31:0] epc, badvaddr, redirect_pc;
  logic        is_bd, we_badvaddr, flush, redirect_valid, busy;
  logic [107:0] all_out;

  int n_checks = 0;
  int n_errors = 0;

  exception_handler #(.N_HWINT(6), .SYNC_STAGES(2), .EXC_VECTOR(32'hBFC00380)) dut (
    .clk(clk), .resetn(resetn), .hw_int(hw_int), .sw_int(sw_int), .int_mask(int_mask),
    .status_ie(status_ie), .status_exl(status_exl), .am_valid(am_valid),
    .am_excep_code(am_excep_code), .am_pc(am_pc), .am_data_addr(am_data_addr),
    .cp0_epc(cp0_epc), .am_is_bd(am_is_bd), .am_adel_if(am_adel_if), .am_eret(am_eret),
    .redirect_ready(redirect_ready), .excep_valid(excep_valid), .eret_commit(eret_commit),
    .excep_code(excep_code), .epc(epc), .badvaddr(badvaddr), .redirect_pc(redirect_pc),
    .is_bd(is_bd), .we_badvaddr(we_badvaddr), .flush(flush),
    .redirect_valid(redirect_valid), .busy(busy)
  );

  assign all_out = {excep_valid, eret_commit, excep_code, epc, badvaddr, redirect_pc,
                    is_bd, we_badvaddr, flush, redirect_valid, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    am_valid      = 1'b0;
    am_excep_code = 5'd0;
    am_eret       = 1'b0;
    am_is_bd      = 1'b0;
    am_adel_if    = 1'b0;
  endtask

  // Accept the redirect and confirm everything returns to zero in IDLE.
  task automatic finish_op(input string tag);
    idle_inputs();
    redirect_ready = 1'b1;
    tick();
    tick();
    check(tag, 128'(all_out), 128'(0));
  endtask

  initial begin
    resetn = 1'b0; hw_int = '0; sw_int = '0; int_mask = '0;
    status_ie = 1'b0; status_exl = 1'b0; redirect_ready = 1'b0;
    am_pc = '0; am_data_addr = '0; cp0_epc = '0;
    idle_inputs();

    // Reset holds everything at zero even with a trigger present
    am_valid = 1'b1; am_excep_code = 5'd8;
    repeat (3) tick();
    check("reset_outs", 128'(all_out), 128'(0));
    idle_inputs();
    resetn = 1'b1;
    tick();
    check("post_reset_idle", 128'(busy), 128'(0));

    // ADEL from data access
    am_valid = 1'b1; am_excep_code = 5'd4; am_adel_if = 1'b0;
    am_data_addr = 32'h0000_1003; am_pc = 32'h8000_0010;
    tick();
    check("adel_excep_valid", 128'(excep_valid), 128'(1));
    check("adel_code", 128'(excep_code), 128'(4));
    check("adel_badvaddr", 128'(badvaddr), 128'(32'h0000_1003));
    check("adel_we", 128'(we_badvaddr), 128'(1));
    check("adel_epc", 128'(epc), 128'(32'h8000_0010));
    check("adel_rpc", 128'(redirect_pc), 128'(32'hBFC0_0380));
    check("adel_flush_ctl", 128'({flush, busy, redirect_valid, eret_commit}), 128'(4'b1100));
    idle_inputs();
    redirect_ready = 1'b1;
    tick();
    check("adel_redirect_ctl", 128'({excep_valid, flush, busy, redirect_valid}), 128'(4'b0111));
    check("adel_hold_badvaddr", 128'(badvaddr), 128'(32'h0000_1003));
    tick();
    check("adel_return_idle", 128'(all_out), 128'(0));

    // ADEL from fetch uses the PC
    am_valid = 1'b1; am_excep_code = 5'd4; am_adel_if = 1'b1; am_pc = 32'h8000_0042;
    tick();
    check("adel_if_badvaddr", 128'(badvaddr), 128'(32'h8000_0042));
    finish_op("adel_if_idle");

    // Overflow in a delay slot
    am_valid = 1'b1; am_excep_code = 5'd12; am_is_bd = 1'b1; am_pc = 32'h8000_0024;
    tick();
    check("ov_epc", 128'(epc), 128'(32'h8000_0020));
    check("ov_isbd", 128'(is_bd), 128'(1));
    check("ov_we", 128'({we_badvaddr, badvaddr}), 128'(0));
    check("ov_code", 128'(excep_code), 128'(12));
    finish_op("ov_idle");

    // Unsupported code and missing am_valid do not trigger
    am_valid = 1'b1; am_excep_code = 5'd3;
    tick();
    check("code3_ignored", 128'(busy), 128'(0));
    am_valid = 1'b0; am_excep_code = 5'd4;
    tick();
    check("novalid_ignored", 128'(busy), 128'(0));

    // Software interrupt: masked, then unmasked
    idle_inputs();
    am_valid = 1'b1; sw_int = 2'b01; status_ie = 1'b1; int_mask = 8'h00;
    tick();
    check("sw_masked", 128'(busy), 128'(0));
    int_mask = 8'h01;
    tick();
    check("sw_int_take", 128'({busy, excep_valid, excep_code}), 128'({2'b11, 5'd0}));
    finish_op("sw_idle");
    sw_int = 2'b00;

    // Hardware interrupt goes through the two-flop synchroniser
    int_mask = 8'h10; hw_int = 6'b000100; am_valid = 1'b1; am_excep_code = 5'd0;
    tick();
    check("hw_sync_edge1", 128'(busy), 128'(0));
    tick();
    check("hw_sync_edge2", 128'(busy), 128'(0));
    tick();
    check("hw_int_take", 128'({busy, excep_valid, excep_code}), 128'({2'b11, 5'd0}));
    finish_op("hw_idle");

    // Interrupt beats ADES
    am_valid = 1'b1; am_excep_code = 5'd5; am_data_addr = 32'h0000_2002;
    tick();
    check("int_over_ades", 128'({excep_code, we_badvaddr, badvaddr}), 128'(0));
    finish_op("int_ades_idle");

    // With EXL set the interrupt is blocked and ADES wins
    status_exl = 1'b1;
    am_valid = 1'b1; am_excep_code = 5'd5;
    tick();
    check("ades_code", 128'(excep_code), 128'(5));
    check("ades_badvaddr", 128'({we_badvaddr, badvaddr}), 128'({1'b1, 32'h0000_2002}));
    finish_op("ades_idle");
    hw_int = '0; status_exl = 1'b0; status_ie = 1'b0; int_mask = '0;

    // ERET followed by a long-held redirect
    redirect_ready = 1'b0;
    am_valid = 1'b1; am_eret = 1'b1; cp0_epc = 32'h8000_0100; am_pc = 32'h8000_0200;
    tick();
    check("eret_ctl", 128'({eret_commit, excep_valid, flush}), 128'(3'b101));
    check("eret_rpc", 128'(redirect_pc), 128'(32'h8000_0100));
    am_eret = 1'b0; am_excep_code = 5'd8;
    tick();
    check("eret_pulse_end", 128'({eret_commit, redirect_valid}), 128'(2'b01));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ctl", 128'({redirect_valid, flush, busy, excep_valid}), 128'(4'b1110));
      check("hold_rpc", 128'({excep_code, redirect_pc}), 128'({5'd0, 32'h8000_0100}));
    end
    redirect_ready = 1'b1;
    tick();
    check("ready_to_idle", 128'({busy, redirect_valid, redirect_pc}), 128'(0));
    tick();
    check("back_to_back", 128'({excep_valid, excep_code}), 128'({1'b1, 5'd8}));
    finish_op("b2b_idle");

    // Asynchronous reset while in REDIRECT
    redirect_ready = 1'b0;
    am_valid = 1'b1; am_excep_code = 5'd9;
    tick();
    idle_inputs();
    tick();
    check("pre_reset_redirect", 128'({redirect_valid, excep_code}), 128'({1'b1, 5'd9}));
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_outs", 128'(all_out), 128'(0));
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_quiet", 128'(all_out), 128'(0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exception_handler.md
EXCEPTION_HANDLER -- requirements
Module: exception_handler

Interface
REQ-001 Parameter N_HWINT, default 6: number of hardware interrupt lines.
REQ-002 Parameter SYNC_STAGES, default 2 (min 2): synchroniser depth on hw_int.
REQ-003 Parameter EXC_VECTOR, default 32'hBFC00380: exception redirect target.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 hw_int  in  N_HWINT  asynchronous level interrupts.
REQ-007 sw_int  in  2  software interrupt bits (already synchronous).
REQ-008 int_mask  in  N_HWINT+2  mask, bit order {hw,sw}.
REQ-009 status_ie, status_exl  in  1 each  CP0 Status IE/EXL.
REQ-010 am_valid  in  1  valid instruction in AM stage.
REQ-011 am_excep_code  in  5  AM-stage exception code (0 = none).
REQ-012 am_pc, am_data_addr, cp0_epc  in  32 each  AM PC, memory address, EPC for ERET.
REQ-013 am_is_bd, am_adel_if, am_eret  in  1 each  delay-slot flag, ADEL from fetch, ERET in AM.
REQ-014 redirect_ready  in  1  fetch accepts redirect.
REQ-015 excep_valid, eret_commit  out  1 each  one-cycle commit pulses to CP0.
REQ-016 excep_code  out  5;  epc, badvaddr, redirect_pc  out  32 each.
REQ-017 is_bd, we_badvaddr, flush, redirect_valid, busy  out  1 each.

Function
REQ-018 Codes: INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12; any other nonzero code is ignored.
REQ-019 hw_int passes SYNC_STAGES flops; pending = {hw_sync, sw_int} & int_mask.
REQ-020 int_take = |pending & status_ie & ~status_exl & am_valid.
REQ-021 Trigger priority in IDLE: int_take > ADEL > ADES > RI/BP/SYS/OV > (am_valid & am_eret); all triggers require am_valid.
REQ-022 FSM states IDLE, FLUSH, REDIRECT; triggers sampled only in IDLE, ignored elsewhere.
REQ-023 IDLE + trigger -> FLUSH next edge; capture code, epc, is_bd, badvaddr, we_badvaddr, redirect_pc, kind (excep/eret).
REQ-024 FLUSH lasts exactly one cycle -> REDIRECT.
REQ-025 REDIRECT holds redirect_valid=1 and stable redirect_pc until redirect_ready=1 sampled -> IDLE next edge.
REQ-026 redirect_ready ignored outside REDIRECT; ready same cycle as entry accepted (REDIRECT lasts min 1 cycle).
REQ-027 excep_valid=1 only in FLUSH cycle for exception kind; eret_commit=1 only in FLUSH cycle for ERET kind.
REQ-028 flush=1 and busy=1 in FLUSH and REDIRECT; 0 in IDLE.
REQ-029 epc = am_pc-4 (mod 2^32) if am_is_bd else am_pc; is_bd = am_is_bd.
REQ-030 ADEL: we_badvaddr=1, badvaddr = am_pc if am_adel_if else am_data_addr.
REQ-031 ADES: we_badvaddr=1, badvaddr = am_data_addr; all other kinds: we_badvaddr=0, badvaddr=0.
REQ-032 redirect_pc = EXC_VECTOR for exceptions, cp0_epc for ERET.
REQ-033 Captured outputs hold in FLUSH/REDIRECT; cleared to 0 on REDIRECT->IDLE.
REQ-034 Back-to-back: trigger in the IDLE cycle right after return is accepted normally.

Reset
REQ-035 resetn=0 forces IDLE, clears synchroniser, all outputs 0, immediately and regardless of state.
REQ-036 Reset mid-FLUSH/REDIRECT abandons operation; no pulse emitted after deassertion.
REQ-037 First trigger honoured no earlier than first edge after resetn rises.

Verification
REQ-038 ADEL: am_valid=1, code=4, am_adel_if=0, am_data_addr=32'h0000_1003, am_pc=32'h8000_0010 -> FLUSH: excep_valid=1, badvaddr=32'h0000_1003, epc=32'h8000_0010; redirect_pc=32'hBFC0_0380.
REQ-039 Delay slot: OV, am_is_bd=1, am_pc=32'h8000_0024 -> epc=32'h8000_0020, is_bd=1, we_badvaddr=0.
REQ-040 Interrupt vs ADES: hw_int[2]=1, mask[4]=1, ie=1, exl=0, code=5 same cycle -> after SYNC_STAGES edges excep_code=0; with exl=1 -> code=5, badvaddr=am_data_addr.
REQ-041 ERET: am_eret=1, cp0_epc=32'h8000_0100 -> eret_commit=1 one cycle, excep_valid=0, redirect_pc=32'h8000_0100.
REQ-042 Handshake: redirect_ready low 5 cycles -> redirect_valid/flush/busy held 5 cycles, new trigger ignored; IDLE one edge after ready.
REQ-043 Reset during REDIRECT -> all outputs 0 immediately, IDLE, no pulses afterward.
